regfile_multiport: RTL and testbench
====================================

Name: regfile_multiport

Overview:
Parametrised successor to the 32x64 register file: configurable data width, depth, read-port count, and hardwired-zero register index. Adds:
- a second write port with fixed priority;
- optional write-to-read bypass;
- a per-register busy scoreboard for pipelined CPU hazard detection.

It sits between the decode stage (reads, allocates) and the writeback stage (writes) of the pipelined datapath.

Parameters:
WIDTH, 64, data bits per register
DEPTH, 32, number of registers; power of two, >=2
AW, $clog2(DEPTH), address width (derived; do not override)
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, DEPTH-1, index hardwired to zero; set to DEPTH to disable
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see stored value only

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high
rd_addr  input  NUM_RD*AW  read addresses; port k uses bits [k*AW +: AW]
rd_data  output  NUM_RD*WIDTH  read data; port k uses bits [k*WIDTH +: WIDTH]
rd_busy  output  NUM_RD  busy bit of each addressed register
wr_en0  input  1  write enable, port 0
wr_addr0  input  AW  write address, port 0
wr_data0  input  WIDTH  write data, port 0
wr_en1  input  1  write enable, port 1 (higher priority)
wr_addr1  input  AW  write address, port 1
wr_data1  input  WIDTH  write data, port 1
alloc_en  input  1  mark a destination register busy (issue)
alloc_addr  input  AW  register to mark busy
busy_vec  output  DEPTH  full scoreboard, bit i = register i busy

Behaviour:
- Reset is synchronous. At a posedge with reset=1:
  - all storage registers clear to 0;
  - all busy bits clear to 0;
  - writes and allocs in that cycle are ignored.
- Post-reset output values: rd_data = 0 for every address, rd_busy = 0, busy_vec = 0.
- Writes:
  - Committed at posedge when wr_enN=1.
  - Write to ZERO_REG is discarded; storage and busy bit are unchanged.
  - wr_en0 and wr_en1 to the same address in the same cycle: port 1 data is stored, port 0 is dropped.
  - Different addresses: both commit.
- Reads are combinational, 0-cycle latency.
  - rd_data for ZERO_REG is always 0, regardless of bypass.
  - BYPASS=1 and a read address matches an enabled write address this cycle: rd_data returns that write's data, port 1 preferred over port 0. Otherwise it returns stored data.
  - BYPASS=0: stored value only; the new value is visible the cycle after the write.
- Scoreboard, per register i, evaluated at posedge when not in reset:
  - set when alloc_en=1 and alloc_addr=i;
  - cleared when an enabled write (either port) targets i;
  - set and clear in the same cycle on i: set wins (a new producer supersedes the completing one);
  - alloc to ZERO_REG is ignored; busy_vec[ZERO_REG] is constant 0.
- rd_busy[k] = busy_vec[rd_addr k], registered value.
  - With BYPASS=1, rd_busy[k] also reads 0 when the addressed register is being written this cycle and not simultaneously allocated.
- Reset mid-operation: all state clears in the reset cycle; inputs are ignored until reset is deasserted.
- No other state. DEPTH entries are fully addressable; there is no out-of-range address.

Test Plan:
1. Reset, then read all 32 addresses on both ports -> all rd_data = 0, busy_vec = 0.
2. wr_en0=1, addr=31, data=0xA0 -> next cycle reading 31 returns 0; busy_vec[31] = 0.
3. Write i*0x0000010204080001 to regs 0..30 via port 0, then read back pairs (i-1, i) with writes off -> each value matches.
4. Same cycle wr_en0 (addr 5, 0x1111) and wr_en1 (addr 5, 0x2222):
   - BYPASS=1, rd_addr=5 -> 0x2222 in the same cycle;
   - stored value 0x2222 afterwards;
   - BYPASS=0 build -> old value that cycle, 0x2222 next cycle.
5. Scoreboard sequence:
   - alloc reg 7 -> busy_vec[7] = 1 next cycle;
   - write reg 7 with alloc_en=0 -> cleared next cycle;
   - alloc 7 and write 7 in the same cycle -> stays 1.
6. Write 0xDEAD to reg 3 and alloc reg 4, then assert reset for 1 cycle -> reg 3 reads 0; busy_vec = 0.

Source files
------------

// File: rtl/regfile_multiport.sv
// Multi-ported register file with two write ports, optional write-to-read
// bypass and a per-register busy scoreboard for hazard detection.
// Sits between decode (reads, allocs) and writeback (writes).

// One read port: picks stored data or forwarded write data, and the busy bit.
module regfile_multiport_rdport #(
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 32,
    parameter int AW       = $clog2(DEPTH),
    parameter int ZERO_REG = DEPTH - 1,
    parameter int BYPASS   = 1
) (
    input  logic [AW-1:0]                  addr_i,
    input  logic [DEPTH-1:0][WIDTH-1:0]    mem_i,
    input  logic [DEPTH-1:0]               busy_i,
    input  logic                           we0_i,
    input  logic [AW-1:0]                  wa0_i,
    input  logic [WIDTH-1:0]               wd0_i,
    input  logic                           we1_i,
    input  logic [AW-1:0]                  wa1_i,
    input  logic [WIDTH-1:0]               wd1_i,
    input  logic                           alloc_i,
    input  logic [AW-1:0]                  alloc_addr_i,
    output logic [WIDTH-1:0]               data_o,
    output logic                           busy_o
);
    // Extra bit so ZERO_REG == DEPTH (disabled) never matches a real address.
    localparam logic [AW:0] ZR = ZERO_REG[AW:0];

    logic hit0, hit1, is_zero, alloc_hit;

    assign hit0      = we0_i && (wa0_i == addr_i);
    assign hit1      = we1_i && (wa1_i == addr_i);
    assign is_zero   = ({1'b0, addr_i} == ZR);
    assign alloc_hit = alloc_i && (alloc_addr_i == addr_i);

    // Read mux: zero register dominates, then port 1 forward, port 0 forward, storage.
    always_comb begin
        data_o = mem_i[addr_i];
        busy_o = busy_i[addr_i];
        if (BYPASS != 0) begin
            if (hit1)
                data_o = wd1_i;
            else if (hit0)
                data_o = wd0_i;
            // A completing write clears the hazard early unless a new producer
            // is issued for the same register this cycle.
            if ((hit0 || hit1) && !alloc_hit)
                busy_o = 1'b0;
        end
        if (is_zero) begin
            data_o = '0;
            busy_o = 1'b0;
        end
    end
endmodule

module regfile_multiport #(
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 32,
    parameter int AW       = $clog2(DEPTH),
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = DEPTH - 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*WIDTH-1:0]  rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en0,
    input  logic [AW-1:0]            wr_addr0,
    input  logic [WIDTH-1:0]         wr_data0,
    input  logic                     wr_en1,
    input  logic [AW-1:0]            wr_addr1,
    input  logic [WIDTH-1:0]         wr_data1,
    input  logic                     alloc_en,
    input  logic [AW-1:0]            alloc_addr,
    output logic [DEPTH-1:0]         busy_vec
);
    localparam logic [AW:0] ZR = ZERO_REG[AW:0];

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [DEPTH-1:0]            busy_q, busy_d;
    logic                        we0, we1, alloc_v;

    // Writes and allocs aimed at the zero register are dropped at the source.
    assign we0     = wr_en0   && ({1'b0, wr_addr0}   != ZR);
    assign we1     = wr_en1   && ({1'b0, wr_addr1}   != ZR);
    assign alloc_v = alloc_en && ({1'b0, alloc_addr} != ZR);

    // Next state: port 1 applied after port 0 so it wins a same-address clash;
    // alloc applied after the clears so a new producer supersedes the old one.
    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        if (we0) begin
            mem_d[wr_addr0]  = wr_data0;
            busy_d[wr_addr0] = 1'b0;
        end
        if (we1) begin
            mem_d[wr_addr1]  = wr_data1;
            busy_d[wr_addr1] = 1'b0;
        end
        if (alloc_v)
            busy_d[alloc_addr] = 1'b1;
    end

    // State registers with synchronous reset; inputs ignored while in reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q  <= '0;
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        regfile_multiport_rdport #(
            .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW),
            .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
        ) u_rd (
            .addr_i      (rd_addr[k*AW +: AW]),
            .mem_i       (mem_q),
            .busy_i      (busy_q),
            .we0_i       (we0),
            .wa0_i       (wr_addr0),
            .wd0_i       (wr_data0),
            .we1_i       (we1),
            .wa1_i       (wr_addr1),
            .wd1_i       (wr_data1),
            .alloc_i     (alloc_v),
            .alloc_addr_i(alloc_addr),
            .data_o      (rd_data[k*WIDTH +: WIDTH]),
            .busy_o      (rd_busy[k])
        );
    end
endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: a bypassing and a non-bypassing instance share
// stimulus and are compared against an array-based reference model.
module tb_regfile_multiport;
    localparam int W = 64, D = 32, AW = 5, NR = 2, ZR = 31;
    localparam logic [63:0] C = 64'h0000010204080001;

    logic clk = 1'b0, reset = 1'b0;
    logic [NR*AW-1:0] rd_addr = '0;
    logic [NR*W-1:0]  rd_data, rd_data_nb;
    logic [NR-1:0]    rd_busy, rd_busy_nb;
    logic             wr_en0 = 0, wr_en1 = 0, alloc_en = 0;
    logic [AW-1:0]    wr_addr0 = '0, wr_addr1 = '0, alloc_addr = '0;
    logic [W-1:0]     wr_data0 = '0, wr_data1 = '0;
    logic [D-1:0]     busy_vec, busy_vec_nb;

    int vectors = 0, miscompares = 0;

    // Reference model state
    logic [W-1:0] mem_m [D];
    logic         busy_m [D];

    always #5 clk = ~clk;

    regfile_multiport #(.WIDTH(W), .DEPTH(D), .NUM_RD(NR), .BYPASS(1)) dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
        .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .busy_vec(busy_vec));

    regfile_multiport #(.WIDTH(W), .DEPTH(D), .NUM_RD(NR), .BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
        .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
        .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .busy_vec(busy_vec_nb));

    function automatic logic [W-1:0] exp_rd(input int a, input bit byp);
        if (a == ZR) return '0;
        if (byp && wr_en1 && int'(wr_addr1) == a) return wr_data1;
        if (byp && wr_en0 && int'(wr_addr0) == a) return wr_data0;
        return mem_m[a];
    endfunction

    function automatic logic exp_busy(input int a, input bit byp);
        bit written, alloced;
        if (a == ZR) return 1'b0;
        written = (wr_en0 && int'(wr_addr0) == a) || (wr_en1 && int'(wr_addr1) == a);
        alloced = alloc_en && int'(alloc_addr) == a;
        if (byp && written && !alloced) return 1'b0;
        return busy_m[a];
    endfunction

    function automatic logic [D-1:0] exp_vec();
        logic [D-1:0] v;
        for (int i = 0; i < D; i++) v[i] = busy_m[i];
        return v;
    endfunction

    // Apply the current inputs to the model, then clock the DUTs.
    task automatic tick();
        if (reset) begin
            for (int i = 0; i < D; i++) begin mem_m[i] = '0; busy_m[i] = 1'b0; end
        end else begin
            if (wr_en0 && wr_addr0 != ZR) begin mem_m[wr_addr0] = wr_data0; busy_m[wr_addr0] = 1'b0; end
            if (wr_en1 && wr_addr1 != ZR) begin mem_m[wr_addr1] = wr_data1; busy_m[wr_addr1] = 1'b0; end
            if (alloc_en && alloc_addr != ZR) busy_m[alloc_addr] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en0 = 0; wr_en1 = 0; alloc_en = 0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1; tick(); reset = 0;
        for (int a = 0; a < D; a++) begin
            rd_addr = {AW'(a), AW'(D - 1 - a)};
            #1;
            for (int k = 0; k < NR; k++) begin
                vectors++;
                if (rd_data[k*W +: W] !== '0 || rd_data_nb[k*W +: W] !== '0 || rd_busy[k] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL reset_rd a=%0d k=%0d got=%h/%h busy=%b want 0", a, k,
                             rd_data[k*W +: W], rd_data_nb[k*W +: W], rd_busy[k]);
                end
            end
        end
        vectors++;
        if (busy_vec !== '0 || busy_vec_nb !== '0) begin
            miscompares++;
            $display("FAIL reset_busy_vec got=%h/%h want 0", busy_vec, busy_vec_nb);
        end
    endtask

    task automatic test_zero_reg();
        wr_en0 = 1; wr_addr0 = 5'd31; wr_data0 = 64'hA0;
        alloc_en = 1; alloc_addr = 5'd31;
        rd_addr = {5'd31, 5'd31};
        #1;
        vectors++;
        if (rd_data[W-1:0] !== '0) begin
            miscompares++;
            $display("FAIL zero_bypass got=%h want 0", rd_data[W-1:0]);
        end
        tick(); idle(); #1;
        vectors++;
        if (rd_data[W-1:0] !== '0 || rd_data_nb[W-1:0] !== '0 || busy_vec[31] !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_store got=%h/%h busy31=%b want 0", rd_data[W-1:0], rd_data_nb[W-1:0], busy_vec[31]);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 31; i++) begin
            wr_en0 = 1; wr_addr0 = AW'(i); wr_data0 = C * 64'(i);
            tick();
        end
        idle();
        for (int i = 1; i < 31; i++) begin
            rd_addr = {AW'(i), AW'(i - 1)};
            #1;
            vectors++;
            if (rd_data[W +: W] !== C * 64'(i) || rd_data[0 +: W] !== C * 64'(i - 1) ||
                rd_data_nb[W +: W] !== C * 64'(i)) begin
                miscompares++;
                $display("FAIL fill_pair i=%0d got=%h,%h want %h,%h", i, rd_data[0 +: W], rd_data[W +: W],
                         C * 64'(i - 1), C * 64'(i));
            end
        end
    endtask

    task automatic test_dual_write();
        wr_en0 = 1; wr_addr0 = 5'd5; wr_data0 = 64'h1111;
        wr_en1 = 1; wr_addr1 = 5'd5; wr_data1 = 64'h2222;
        rd_addr = {5'd0, 5'd5};
        #1;
        vectors++;
        if (rd_data[0 +: W] !== 64'h2222) begin
            miscompares++;
            $display("FAIL dual_bypass got=%h want 2222", rd_data[0 +: W]);
        end
        vectors++;
        if (rd_data_nb[0 +: W] !== C * 64'd5) begin
            miscompares++;
            $display("FAIL dual_nobypass_old got=%h want %h", rd_data_nb[0 +: W], C * 64'd5);
        end
        tick(); idle(); #1;
        vectors++;
        if (rd_data[0 +: W] !== 64'h2222 || rd_data_nb[0 +: W] !== 64'h2222) begin
            miscompares++;
            $display("FAIL dual_stored got=%h/%h want 2222", rd_data[0 +: W], rd_data_nb[0 +: W]);
        end
    endtask

    task automatic test_scoreboard();
        rd_addr = {5'd7, 5'd7};
        alloc_en = 1; alloc_addr = 5'd7;
        tick(); idle(); #1;
        vectors++;
        if (busy_vec[7] !== 1'b1 || rd_busy[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL sb_alloc busy=%b rd_busy=%b want 1", busy_vec[7], rd_busy[0]);
        end
        wr_en0 = 1; wr_addr0 = 5'd7; wr_data0 = 64'h77;
        #1;
        vectors++;
        if (rd_busy[0] !== 1'b0 || rd_busy_nb[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL sb_write_bypass got=%b/%b want 0/1", rd_busy[0], rd_busy_nb[0]);
        end
        tick(); idle(); #1;
        vectors++;
        if (busy_vec[7] !== 1'b0) begin
            miscompares++;
            $display("FAIL sb_clear got=%b want 0", busy_vec[7]);
        end
        alloc_en = 1; alloc_addr = 5'd7;
        wr_en1 = 1; wr_addr1 = 5'd7; wr_data1 = 64'h78;
        #1;
        vectors++;
        if (rd_busy[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL sb_set_clear_comb got=%b want 0", rd_busy[0]);
        end
        tick(); idle(); #1;
        vectors++;
        if (busy_vec[7] !== 1'b1 || busy_vec_nb[7] !== 1'b1) begin
            miscompares++;
            $display("FAIL sb_set_wins got=%b/%b want 1", busy_vec[7], busy_vec_nb[7]);
        end
    endtask

    task automatic test_reset_mid();
        wr_en0 = 1; wr_addr0 = 5'd3; wr_data0 = 64'hDEAD;
        alloc_en = 1; alloc_addr = 5'd4;
        tick(); idle();
        rd_addr = {5'd4, 5'd3};
        #1;
        vectors++;
        if (rd_data[0 +: W] !== 64'hDEAD || busy_vec[4] !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_pre got=%h busy4=%b want dead/1", rd_data[0 +: W], busy_vec[4]);
        end
        reset = 1; tick(); reset = 0; #1;
        vectors++;
        if (rd_data[0 +: W] !== '0 || busy_vec !== '0 || rd_busy !== '0) begin
            miscompares++;
            $display("FAIL mid_reset got=%h busy_vec=%h want 0", rd_data[0 +: W], busy_vec);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            wr_en0 = 1'($urandom_range(0, 1)); wr_addr0 = AW'($urandom_range(0, 31));
            wr_data0 = {$urandom, $urandom};
            wr_en1 = 1'($urandom_range(0, 1)); wr_addr1 = AW'($urandom_range(0, 31));
            wr_data1 = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) wr_addr1 = wr_addr0;
            alloc_en = 1'($urandom_range(0, 1)); alloc_addr = AW'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) alloc_addr = wr_addr0;
            rd_addr = {AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31))};
            if ($urandom_range(0, 2) == 0) rd_addr[AW-1:0] = wr_addr0;
            if ($urandom_range(0, 2) == 0) rd_addr[AW +: AW] = wr_addr1;
            #1;
            for (int k = 0; k < NR; k++) begin
                int a;
                a = int'(rd_addr[k*AW +: AW]);
                vectors++;
                if (rd_data[k*W +: W] !== exp_rd(a, 1) || rd_data_nb[k*W +: W] !== exp_rd(a, 0)) begin
                    miscompares++;
                    $display("FAIL rand_rd n=%0d k=%0d a=%0d got=%h/%h want %h/%h", n, k, a,
                             rd_data[k*W +: W], rd_data_nb[k*W +: W], exp_rd(a, 1), exp_rd(a, 0));
                end
                vectors++;
                if (rd_busy[k] !== exp_busy(a, 1) || rd_busy_nb[k] !== exp_busy(a, 0)) begin
                    miscompares++;
                    $display("FAIL rand_busy n=%0d k=%0d a=%0d got=%b/%b want %b/%b", n, k, a,
                             rd_busy[k], rd_busy_nb[k], exp_busy(a, 1), exp_busy(a, 0));
                end
            end
            vectors++;
            if (busy_vec !== exp_vec() || busy_vec_nb !== exp_vec()) begin
                miscompares++;
                $display("FAIL rand_vec n=%0d got=%h want %h", n, busy_vec, exp_vec());
            end
            tick();
        end
        idle();
    endtask

    initial begin
        for (int i = 0; i < D; i++) begin mem_m[i] = '0; busy_m[i] = 1'b0; end
        @(negedge clk);
        test_reset();
        test_zero_reg();
        test_fill();
        test_dual_write();
        test_scoreboard();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
